// File: rtl/hex_disp_pkg.sv
// Shared character codes, active-low segment patterns and the character decoder
// for the scrolling seven-segment message display.
package hex_disp_pkg;

   // Character codes held in the message register
   localparam int unsigned CHAR_H     = 0;
   localparam int unsigned CHAR_E     = 1;
   localparam int unsigned CHAR_L     = 2;
   localparam int unsigned CHAR_O     = 3;
   localparam int unsigned CHAR_BLANK = 7;

   // Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g
   localparam logic [6:0] SEG_H   = 7'b0001001;
   localparam logic [6:0] SEG_E   = 7'b0000110;
   localparam logic [6:0] SEG_L   = 7'b1000111;
   localparam logic [6:0] SEG_O   = 7'b1000000;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Codes 0..3 are letters; every other code renders as a dark digit
   function automatic logic [6:0] char_decode(input logic [31:0] code);
      logic [6:0] seg;
      case (code)
         32'(CHAR_H): seg = SEG_H;
         32'(CHAR_E): seg = SEG_E;
         32'(CHAR_L): seg = SEG_L;
         32'(CHAR_O): seg = SEG_O;
         default:     seg = SEG_OFF;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/hex_scroll_display_char_to_seg.sv
// Purely combinational decode of one character code into a seven-segment pattern.
module char_to_seg
   import hex_disp_pkg::*;
#(
   parameter int CHAR_W = 3
)(
   input  logic [CHAR_W-1:0] i_char,
   output logic [6:0]        o_seg
);

   // Zero-extend the code so any character width shares one decoder
   assign o_seg = char_decode(32'(i_char));

endmodule

// File: rtl/hex_scroll_display.sv
// Message register driving NUM_DIGITS seven-segment digits, with a programmable
// auto-scroll tick, manual stepping in either direction and a registered output.
module hex_scroll_display
   import hex_disp_pkg::*;
#(
   parameter int NUM_DIGITS = 5,
   parameter int CHAR_W     = 3,
   parameter int TICK_DIV   = 50000000,
   localparam int OW        = $clog2(NUM_DIGITS),
   localparam int CW        = $clog2(TICK_DIV)
)(
   input  logic                         CLOCK_50,
   input  logic                         rst,
   input  logic [NUM_DIGITS*CHAR_W-1:0] chars,
   input  logic                         load,
   input  logic                         enable,
   input  logic                         dir,
   input  logic                         step,
   output logic [NUM_DIGITS*7-1:0]      hex_seg,
   output logic [OW-1:0]                offset
);

   logic [CHAR_W-1:0]              r_msg [NUM_DIGITS];
   logic [OW-1:0]                  r_off;
   logic [CW-1:0]                  r_cnt;
   logic [NUM_DIGITS-1:0][6:0]     r_seg;

   logic                           w_tick;
   logic                           w_adv;
   logic [OW-1:0]                  w_off_nxt;
   logic [NUM_DIGITS-1:0][6:0]     w_seg;

   // Tick only fires while running, so a paused counter parked at the top cannot spin the offset
   assign w_tick = enable && (r_cnt == CW'(TICK_DIV - 1));
   assign w_adv  = w_tick || step;

   // Next offset for one advance, wrapping explicitly so non-power-of-2 sizes stay in range
   always_comb begin
      w_off_nxt = r_off;
      if (dir) begin
         w_off_nxt = (r_off == '0) ? OW'(NUM_DIGITS - 1) : r_off - OW'(1);
      end else begin
         w_off_nxt = (r_off == OW'(NUM_DIGITS - 1)) ? '0 : r_off + OW'(1);
      end
   end

   // Message, tick counter and offset state; load overrides any coincident advance
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         for (int i = 0; i < NUM_DIGITS; i++) r_msg[i] <= CHAR_W'(CHAR_BLANK);
         r_off <= '0;
         r_cnt <= '0;
      end else if (load) begin
         for (int i = 0; i < NUM_DIGITS; i++)
            r_msg[i] <= chars[(NUM_DIGITS-1-i)*CHAR_W +: CHAR_W];
         r_off <= '0;
         r_cnt <= '0;
      end else begin
         if (enable) r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
         if (w_adv)  r_off <= w_off_nxt;
      end
   end

   // Rotation mux and decoder per digit; digit p shows ((N-1-p) + offset) mod N
   for (genvar p = 0; p < NUM_DIGITS; p++) begin : g_dig
      localparam int BASE = NUM_DIGITS - 1 - p;
      logic [OW:0]       w_sum;
      logic [OW-1:0]     w_idx;
      logic [CHAR_W-1:0] w_char;

      assign w_sum  = {1'b0, r_off} + (OW+1)'(BASE);
      assign w_idx  = (w_sum >= (OW+1)'(NUM_DIGITS)) ?
                      OW'(w_sum - (OW+1)'(NUM_DIGITS)) : w_sum[OW-1:0];
      assign w_char = r_msg[w_idx];

      char_to_seg #(.CHAR_W(CHAR_W)) u_dec (
         .i_char (w_char),
         .o_seg  (w_seg[p])
      );
   end

   // Output register: one cycle behind message/offset, dark out of reset
   always_ff @(posedge CLOCK_50) begin
      if (rst) r_seg <= '1;
      else     r_seg <= w_seg;
   end

   assign hex_seg = r_seg;
   assign offset  = r_off;

endmodule

// File: tb/tb_hex_scroll_display.sv
// Directed bench for hex_scroll_display (5 digits, tick every 4 cycles) with a
// cycle-level reference model and hand-computed literal checkpoints.
module tb_hex_scroll_display;

   localparam int N  = 5;
   localparam int CW = 3;
   localparam int TD = 4;

   logic          clk = 1'b0;
   logic          rst, load, enable, dir, step;
   logic [N*CW-1:0] chars;
   logic [N*7-1:0]  hex_seg;
   logic [2:0]      offset;

   int vectors = 0;
   int errors  = 0;

   hex_scroll_display #(.NUM_DIGITS(N), .CHAR_W(CW), .TICK_DIV(TD)) dut (
      .CLOCK_50 (clk),
      .rst      (rst),
      .chars    (chars),
      .load     (load),
      .enable   (enable),
      .dir      (dir),
      .step     (step),
      .hex_seg  (hex_seg),
      .offset   (offset)
   );

   always #5 clk = ~clk;

   // Reference model state
   int            m_msg [N];
   int            m_off;
   int            m_cnt;
   logic [N*7-1:0] m_seg;
   bit            m_valid = 0;

   function automatic logic [6:0] seg_of(input int c);
      case (c)
         0:       return 7'h09;
         1:       return 7'h06;
         2:       return 7'h47;
         3:       return 7'h40;
         default: return 7'h7F;
      endcase
   endfunction

   // What the display must show for a given message and rotation
   function automatic logic [N*7-1:0] render(input int msg [N], input int off);
      logic [N*7-1:0] v;
      v = '0;
      for (int p = 0; p < N; p++) v[p*7 +: 7] = seg_of(msg[(N - 1 - p + off) % N]);
      return v;
   endfunction

   // Model advances on each rising edge from the inputs that edge samples
   always @(posedge clk) begin
      bit tick;
      m_seg = rst ? {(N*7){1'b1}} : render(m_msg, m_off);
      tick  = enable && (m_cnt == TD - 1);
      if (rst) begin
         for (int i = 0; i < N; i++) m_msg[i] = 7;
         m_off = 0;
         m_cnt = 0;
      end else if (load) begin
         for (int i = 0; i < N; i++) m_msg[i] = int'(chars[(N-1-i)*CW +: CW]);
         m_off = 0;
         m_cnt = 0;
      end else begin
         if (enable) m_cnt = (m_cnt + 1) % TD;
         if (tick || step) m_off = dir ? (m_off + N - 1) % N : (m_off + 1) % N;
      end
      m_valid = 1;
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (m_valid) begin
         check("model_seg", 64'(hex_seg), 64'(m_seg));
         check("model_off", 64'(offset), 64'(m_off));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   localparam logic [6:0] H = 7'h09, E = 7'h06, L = 7'h47, O = 7'h40, B = 7'h7F;

   initial begin
      rst = 1; load = 0; enable = 0; dir = 0; step = 0; chars = '0;
      cyc(2);
      check("reset_seg", 64'(hex_seg), 64'(35'h7FFFFFFFF));
      check("reset_off", 64'(offset), 64'd0);

      rst = 0;
      cyc(20);
      check("idle_seg", 64'(hex_seg), 64'(35'h7FFFFFFFF));
      check("idle_off", 64'(offset), 64'd0);

      // Load HELLO while paused
      chars = 15'b000_001_010_010_011; load = 1;
      cyc(1); load = 0;
      cyc(1);
      check("hello_seg", 64'(hex_seg), 64'({H, E, L, L, O}));
      check("hello_off", 64'(offset), 64'd0);

      // Reload with auto-scroll left running
      load = 1; enable = 1; dir = 0;
      cyc(1); load = 0;
      cyc(4);
      check("left1_off", 64'(offset), 64'd1);
      cyc(1);
      check("left1_seg", 64'(hex_seg), 64'({E, L, L, O, H}));
      cyc(15);
      check("left_wrap_off", 64'(offset), 64'd0);

      // Manual step right from offset 0 wraps to 4
      enable = 0; dir = 1; step = 1;
      cyc(1); step = 0;
      check("right_wrap_off", 64'(offset), 64'd4);
      cyc(1);
      check("right_wrap_seg", 64'(hex_seg), 64'({O, H, E, L, L}));

      // Step coincident with tick: one advance only (4 -> 0)
      enable = 1; dir = 0;
      cyc(3);
      step = 1;
      cyc(1); step = 0;
      check("step_tick_off", 64'(offset), 64'd0);

      // Load coincident with step: load wins
      chars = 15'b011_010_001_000_111; load = 1; step = 1;
      cyc(1); load = 0; step = 0;
      check("load_step_off", 64'(offset), 64'd0);
      cyc(1);
      check("load_step_seg", 64'(hex_seg), 64'({O, L, E, H, B}));

      // Pause with counter at 2, then resume: tick one cycle later
      cyc(1);
      enable = 0;
      cyc(5);
      check("pause_off", 64'(offset), 64'd0);
      enable = 1;
      cyc(1);
      check("resume_pre_off", 64'(offset), 64'd0);
      cyc(1);
      check("resume_adv_off", 64'(offset), 64'd1);

      // Reset mid-scroll at offset 3
      cyc(8);
      check("pre_rst_off", 64'(offset), 64'd3);
      rst = 1;
      cyc(1);
      rst = 0;
      check("mid_rst_off", 64'(offset), 64'd0);
      check("mid_rst_seg", 64'(hex_seg), 64'(35'h7FFFFFFFF));
      cyc(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
